// File: rtl/dcpu_pkg.sv
// Shared dcpu constants: core FSM states, memory arbiter states and grant IDs,
// plus the round-robin pick used by the arbiter.
package dcpu_pkg;

  typedef enum logic [1:0] {
    FETCH_START,
    FETCH_WAIT,
    EXECUTE_START,
    EXECUTE_WAIT
  } core_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_IF,
    ARB_GNT_D
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_e;

  // On a tie the requester that did not own the previous bus cycle wins.
  function automatic grant_e arb_pick(input logic if_req, input logic d_req,
                                      input grant_e last);
    grant_e win;
    if (if_req && d_req) begin
      if (last == GNT_D) win = GNT_IF;
      else               win = GNT_D;
    end else if (if_req) begin
      win = GNT_IF;
    end else begin
      win = GNT_D;
    end
    return win;
  endfunction

endpackage

// File: rtl/dcpu_arb_timer.sv
// Bus-cycle timeout counter for the dcpu memory arbiter; used only when
// DCPU_ARB_TIMEOUT_EN is defined.
module dcpu_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged on the edge that would bring the count to TIMEOUT.
  assign o_expired = i_en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dcpu_mem_arbiter.sv
// Shares the dcpu memory port between instruction fetch and data load/store.
// Optional bus timeout is enabled with the DCPU_ARB_TIMEOUT_EN macro.
module dcpu_mem_arbiter
  import dcpu_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_data,
  output logic          o_if_valid,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_valid,
  output logic          o_mem_cyc,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_err
);

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  grant_e        win;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          err_q, err_d;
  logic          if_req_m, d_req_m;
  logic          timeout_hit;

  // A requester still seeing its valid pulse holds a stale request; ignore it.
  assign if_req_m = i_if_req && !if_valid_q;
  assign d_req_m  = i_d_req  && !d_valid_q;

`ifdef DCPU_ARB_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_en;

  assign tmr_clr = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);
  assign tmr_en  = cyc_q && !i_mem_ack;

  dcpu_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .o_expired(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win          = arb_pick(if_req_m, d_req_m, last_grant_q);
    cyc_d        = cyc_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_data_d    = if_data_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (if_req_m || d_req_m) begin
          cyc_d        = 1'b1;
          last_grant_d = win;
          if (win == GNT_IF) begin
            state_d = ARB_GNT_IF;
            we_d    = 1'b0;
            addr_d  = i_if_addr;
            wdata_d = '0;
          end else begin
            state_d = ARB_GNT_D;
            we_d    = i_d_we;
            addr_d  = i_d_addr;
            wdata_d = i_d_wdata;
          end
        end
      end
      ARB_GNT_IF: begin
        if (i_mem_ack) begin
          state_d    = ARB_IDLE;
          cyc_d      = 1'b0;
          if_data_d  = i_mem_rdata;
          if_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d    = ARB_IDLE;
          cyc_d      = 1'b0;
          if_data_d  = '0;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
        end
      end
      ARB_GNT_D: begin
        // Stores complete without touching the load data register.
        if (i_mem_ack) begin
          state_d   = ARB_IDLE;
          cyc_d     = 1'b0;
          d_valid_d = 1'b1;
          if (!we_q) d_rdata_d = i_mem_rdata;
        end else if (timeout_hit) begin
          state_d   = ARB_IDLE;
          cyc_d     = 1'b0;
          d_valid_d = 1'b1;
          err_d     = 1'b1;
          if (!we_q) d_rdata_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_D;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_data_q    <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_data_q    <= if_data_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
    end
  end

  assign o_mem_cyc   = cyc_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_if_data   = if_data_q;
  assign o_if_valid  = if_valid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_d_valid   = d_valid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_dcpu_mem_arbiter.sv
// Directed bench for dcpu_mem_arbiter; inputs change and outputs are checked
// on the falling edge. The timeout case runs only when DCPU_ARB_TIMEOUT_EN is defined.
module tb_dcpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        mem_cyc;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcpu_mem_arbiter #(
    .AW(16), .DW(16), .TIMEOUT(4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_data  (if_data),
    .o_if_valid (if_valid),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_rdata  (d_rdata),
    .o_d_valid  (d_valid),
    .o_mem_cyc  (mem_cyc),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_ack  (mem_ack),
    .o_err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    nclk(); nclk();
    chk("rst_cyc", mem_cyc, 0);
    chk("rst_ifv", if_valid, 0);
    chk("rst_dv", d_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // 1: fetch only, ack two cycles after cyc rises
    if_req = 1'b1; if_addr = 16'h0010;
    nclk();
    chk("t1_cyc", mem_cyc, 1);
    chk("t1_addr", mem_addr, 16'h0010);
    chk("t1_we", mem_we, 0);
    nclk();
    chk("t1_cyc_hold", mem_cyc, 1);
    chk("t1_ifv_early", if_valid, 0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    nclk();
    chk("t1_ifv", if_valid, 1);
    chk("t1_data", if_data, 16'hBEEF);
    chk("t1_cyc_off", mem_cyc, 0);
    mem_ack = 1'b0; if_req = 1'b0;
    nclk();
    chk("t1_ifv_pulse", if_valid, 0);
    chk("t1_idle", mem_cyc, 0);

    // 2: tie after reset -> fetch, then data, repeat tie -> fetch
    rst = 1'b1; nclk(); rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    nclk();
    chk("t2_first_addr", mem_addr, 16'h0100);
    chk("t2_first_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    nclk();
    chk("t2_ifv", if_valid, 1);
    chk("t2_ifdata", if_data, 16'h1111);
    chk("t2_dv_none", d_valid, 0);
    mem_ack = 1'b0; if_req = 1'b0;
    nclk();
    chk("t2_second_cyc", mem_cyc, 1);
    chk("t2_second_addr", mem_addr, 16'h0300);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    nclk();
    chk("t2_dv", d_valid, 1);
    chk("t2_drdata", d_rdata, 16'h2222);
    chk("t2_ifv_none", if_valid, 0);
    mem_ack = 1'b0; d_req = 1'b0;
    nclk();
    chk("t2_gap", mem_cyc, 0);
    if_req = 1'b1; d_req = 1'b1;
    nclk();
    chk("t2_retie_addr", mem_addr, 16'h0100);
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    nclk();
    chk("t2_retie_ifv", if_valid, 1);
    mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
    nclk();
    chk("t2_retie_idle", mem_cyc, 0);

    // 3: store keeps bus stable and leaves load data unchanged
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    nclk();
    chk("t3_cyc", mem_cyc, 1);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 16'h0200);
    chk("t3_wdata", mem_wdata, 16'h1234);
    d_addr = 16'hFFFF; d_wdata = 16'h0000;
    nclk();
    chk("t3_addr_stable", mem_addr, 16'h0200);
    chk("t3_wdata_stable", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    nclk();
    chk("t3_dv", d_valid, 1);
    chk("t3_rdata_kept", d_rdata, 16'h2222);
    chk("t3_cyc_off", mem_cyc, 0);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    nclk();
    chk("t3_dv_pulse", d_valid, 0);

    // 4: fetch request held through its valid cycle is not re-granted
    if_req = 1'b1; if_addr = 16'h0020;
    nclk();
    chk("t4_cyc", mem_cyc, 1);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    nclk();
    chk("t4_ifv", if_valid, 1);
    chk("t4_data", if_data, 16'h5555);
    mem_ack = 1'b0;
    nclk();
    chk("t4_no_regrant", mem_cyc, 0);
    chk("t4_ifv_off", if_valid, 0);
    if_req = 1'b0;
    nclk();
    chk("t4_idle", mem_cyc, 0);

    // stray ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    nclk();
    chk("stray_ifv", if_valid, 0);
    chk("stray_dv", d_valid, 0);
    chk("stray_ifdata", if_data, 16'h5555);
    mem_ack = 1'b0;

    // 5: reset during a load kills the cycle; later ack is ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    nclk();
    chk("t5_cyc", mem_cyc, 1);
    rst = 1'b1; d_req = 1'b0;
    nclk();
    chk("t5_cyc_drop", mem_cyc, 0);
    chk("t5_dv_none", d_valid, 0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    nclk();
    chk("t5_ack_ign_dv", d_valid, 0);
    chk("t5_ack_ign_cyc", mem_cyc, 0);
    chk("t5_rdata", d_rdata, 0);
    mem_ack = 1'b0;

`ifdef DCPU_ARB_TIMEOUT_EN
    // 6: load to seed rdata, then a load with no ack times out after 4 cycles
    d_req = 1'b1; d_addr = 16'h0500;
    nclk();
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    nclk();
    chk("t6_seed", d_rdata, 16'h9999);
    mem_ack = 1'b0; d_req = 1'b0;
    nclk();
    d_req = 1'b1; d_addr = 16'h0600;
    for (int i = 0; i < 4; i++) begin
      nclk();
      chk("t6_cyc_wait", mem_cyc, 1);
      chk("t6_err_wait", err, 0);
    end
    nclk();
    chk("t6_cyc_drop", mem_cyc, 0);
    chk("t6_err", err, 1);
    chk("t6_dv", d_valid, 1);
    chk("t6_rdata", d_rdata, 0);
    d_req = 1'b0;
    nclk();
    chk("t6_err_pulse", err, 0);
`else
    // 6: without the timeout the cycle waits indefinitely and o_err stays 0
    d_req = 1'b1; d_addr = 16'h0600;
    for (int i = 0; i < 6; i++) begin
      nclk();
      chk("t6_cyc_wait", mem_cyc, 1);
      chk("t6_err_zero", err, 0);
      chk("t6_dv_none", d_valid, 0);
    end
    mem_ack = 1'b1; mem_rdata = 16'h4321;
    nclk();
    chk("t6_dv", d_valid, 1);
    chk("t6_rdata", d_rdata, 16'h4321);
    chk("t6_err_done", err, 0);
    mem_ack = 1'b0; d_req = 1'b0;
    nclk();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
